// File: rtl/motor_ramp_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp_bridge_ctrl
// Description : Drives one L298 H-bridge channel. The ENA pin carries a PWM
//               waveform whose duty ramps toward a clamped percent target.
//               IN1/IN2 select the direction. A direction reversal first
//               ramps the duty down to 0. It then holds both direction pins
//               low for a dead time before the bridge runs in the new
//               direction.
// Ports       : w5       - system clock; all logic runs on its rising edge
//               u18      - synchronous active-high reset
//               cmd_duty - target duty in percent; values above 100 clamp
//               cmd_dir  - requested direction (0 forward, 1 reverse)
//               ena      - PWM output to L298 ENA
//               in1      - L298 IN1 (forward drive)
//               in2      - L298 IN2 (reverse drive)
//               cur_duty - duty currently applied, 0..100
//               busy     - high while a reversal is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp_bridge_ctrl #(
   parameter int PRESCALE     = 1000,
   parameter int PWM_STEPS    = 100,
   parameter int RAMP_PERIODS = 4,
   parameter int DEAD_PERIODS = 8
) (
   input  logic       w5,
   input  logic       u18,
   input  logic [7:0] cmd_duty,
   input  logic       cmd_dir,
   output logic       ena,
   output logic       in1,
   output logic       in2,
   output logic [7:0] cur_duty,
   output logic       busy
);

   localparam int c_pre_w  = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
   localparam int c_pwm_w  = (PWM_STEPS > 1)    ? $clog2(PWM_STEPS)    : 1;
   localparam int c_ramp_w = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam int c_dead_w = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

   localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(PRESCALE - 1);
   localparam logic [c_pwm_w-1:0]  c_pwm_last  = c_pwm_w'(PWM_STEPS - 1);
   localparam logic [c_ramp_w-1:0] c_ramp_last = c_ramp_w'(RAMP_PERIODS - 1);
   localparam logic [c_dead_w-1:0] c_dead_last = c_dead_w'(DEAD_PERIODS - 1);
   localparam logic [7:0]          c_duty_max  = 8'd100;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_RAMP_DOWN = 2'd2,
      ST_DEAD      = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_pre_w-1:0]  r_pre;
   logic [c_pwm_w-1:0]  r_pwm;
   logic [c_ramp_w-1:0] r_ramp;
   logic [c_dead_w-1:0] r_dead;
   logic [7:0]          r_duty;
   logic [7:0]          w_duty_nxt;
   logic                r_dir;
   logic                w_dir_nxt;
   logic                r_ena;
   logic                r_in1;
   logic                r_in2;
   logic                r_busy;

   logic                w_tick;
   logic                w_period_end;
   logic                w_step;
   logic                w_dead_last;
   logic                w_ramp_clr;
   logic [7:0]          w_tgt;
   logic [7:0]          w_pwm_ext;
   logic                w_drive;

   assign w_tgt        = (cmd_duty > c_duty_max) ? c_duty_max : cmd_duty;
   assign w_tick       = (r_pre == c_pre_last);
   assign w_period_end = w_tick && (r_pwm == c_pwm_last);
   assign w_step       = w_period_end && (r_ramp == c_ramp_last);
   assign w_dead_last  = w_period_end && (r_dead == c_dead_last);
   assign w_pwm_ext    = 8'(r_pwm);

   // The ramp counter restarts whenever RUN or RAMP_DOWN is entered.
   // The first duty step in a new state therefore always follows a full
   // RAMP_PERIODS interval.
   assign w_ramp_clr   = (w_state_nxt != r_state) &&
                         ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_RAMP_DOWN));

   // The bridge is driven in RUN and also through RAMP_DOWN. The direction
   // pins therefore keep their RUN values until the duty reaches 0.
   assign w_drive      = (r_state == ST_RUN) || (r_state == ST_RAMP_DOWN);

   // Next-state and next-duty decisions. These only fire at period_end, so
   // every PWM period runs to completion with a constant duty.
   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_dir_nxt   = r_dir;
      if (w_period_end) begin
         case (r_state)
            ST_IDLE: begin
               w_duty_nxt = '0;
               if (w_tgt != 8'd0) begin
                  w_dir_nxt   = cmd_dir;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               // A direction change has priority over ramping toward the target.
               if (cmd_dir != r_dir) begin
                  w_state_nxt = (r_duty != 8'd0) ? ST_RAMP_DOWN : ST_DEAD;
               end else if ((r_duty == 8'd0) && (w_tgt == 8'd0)) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_step) begin
                  if (r_duty < w_tgt) begin
                     w_duty_nxt = r_duty + 8'd1;
                  end else if (r_duty > w_tgt) begin
                     w_duty_nxt = r_duty - 8'd1;
                  end
               end
            end
            ST_RAMP_DOWN: begin
               // Once a reversal starts, it completes. The target and the
               // direction request are ignored until DEAD ends.
               if (r_duty == 8'd0) begin
                  w_state_nxt = ST_DEAD;
               end else if (w_step) begin
                  w_duty_nxt = r_duty - 8'd1;
               end
            end
            ST_DEAD: begin
               if (w_dead_last) begin
                  w_dir_nxt   = cmd_dir;
                  w_state_nxt = (w_tgt != 8'd0) ? ST_RUN : ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge w5) begin
      if (u18) begin
         r_state <= ST_IDLE;
         r_pre   <= '0;
         r_pwm   <= '0;
         r_ramp  <= '0;
         r_dead  <= '0;
         r_duty  <= '0;
         r_dir   <= 1'b0;
         r_ena   <= 1'b0;
         r_in1   <= 1'b0;
         r_in2   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_duty  <= w_duty_nxt;
         r_dir   <= w_dir_nxt;

         // Prescaler and PWM counter free-run in every state.
         r_pre <= w_tick ? '0 : r_pre + c_pre_w'(1);
         if (w_tick) begin
            r_pwm <= (r_pwm == c_pwm_last) ? '0 : r_pwm + c_pwm_w'(1);
         end

         if (w_ramp_clr) begin
            r_ramp <= '0;
         end else if (w_period_end && w_drive) begin
            r_ramp <= (r_ramp == c_ramp_last) ? '0 : r_ramp + c_ramp_w'(1);
         end

         if (r_state != ST_DEAD) begin
            r_dead <= '0;
         end else if (w_period_end) begin
            r_dead <= (r_dead == c_dead_last) ? '0 : r_dead + c_dead_w'(1);
         end

         // Strict compare: duty 0 never asserts ENA. At 100 every count
         // 0..99 is below the duty, so ENA never drops at the wrap.
         r_ena  <= (w_pwm_ext < r_duty);
         r_in1  <= w_drive && !r_dir;
         r_in2  <= w_drive &&  r_dir;
         r_busy <= (r_state == ST_RAMP_DOWN) || (r_state == ST_DEAD);
      end
   end

   assign ena      = r_ena;
   assign in1      = r_in1;
   assign in2      = r_in2;
   assign cur_duty = r_duty;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: doc/motor_ramp_bridge_ctrl.md
Name: motor_ramp_bridge_ctrl

Overview:
Downstream stage of the switch-decoded duty/direction selector. It drives one L298 H-bridge channel. It takes a target duty in percent (0-100) plus a direction request and generates the ENA PWM waveform and the IN1/IN2 direction pins. Duty ramps gradually toward the target. A direction reversal always ramps to 0, holds both pins low for a dead time, then ramps up in the new direction.

Parameters:
PRESCALE, 1000, clocks per PWM tick (100 MHz / 1000 / 100 ticks = 1 kHz PWM)
PWM_STEPS, 100, PWM ticks per period; duty compare resolution (1 %)
RAMP_PERIODS, 4, completed PWM periods per 1 % duty change
DEAD_PERIODS, 8, completed PWM periods with IN1=IN2=0 during a reversal

Ports:
w5  in  1  100 MHz system clock; all logic on its rising edge
u18  in  1  reset, synchronous, active-high
cmd_duty  in  8  target duty in %; values >100 are clamped to 100
cmd_dir  in  1  requested direction: 0 = forward, 1 = reverse
ena  out  1  PWM to L298 ENA
in1  out  1  L298 IN1 (forward drive)
in2  out  1  L298 IN2 (reverse drive)
cur_duty  out  8  duty currently applied, 0-100
busy  out  1  high while a reversal is in progress (RAMP_DOWN or DEAD)

Behaviour:
- Reset (u18=1 at a w5 edge): next cycle has state=IDLE; all counters 0; cur_duty=0; ena=in1=in2=busy=0; cur_dir=0. Reset wins over every other event, including mid-ramp and mid-dead-time.
- Target: tgt = min(cmd_duty, 100). Inputs are sampled every clock and need no handshake.
- Prescaler: runs 0..PRESCALE-1; tick asserts for 1 clock when the count is PRESCALE-1.
- PWM counter: runs 0..PWM_STEPS-1 and advances on tick. period_end = tick AND pwm_cnt==PWM_STEPS-1. Both counters free-run in every state.
- ena is registered: ena <= (pwm_cnt < cur_duty). One clock latency from counter to pin. Duty 0 gives ena constantly 0; duty 100 gives ena constantly 1 (no glitch at wrap).
- cur_duty and all state changes take effect only at period_end. Every PWM period is therefore complete and glitch-free.
- Ramp step counter: counts period_ends 0..RAMP_PERIODS-1. step = period_end AND count==RAMP_PERIODS-1. It is cleared on entry to RUN and to RAMP_DOWN.
- in1/in2 are registered from state and cur_dir:
  - RUN with cur_dir=0: in1=1, in2=0.
  - RUN with cur_dir=1: in1=0, in2=1.
  - IDLE or DEAD: both 0.
  - RAMP_DOWN: hold the RUN values.
  - in1=in2=1 never occurs.
- FSM:
  - IDLE: cur_duty=0. If tgt>0 at period_end: cur_dir<=cmd_dir, go to RUN.
  - RUN:
    - If cmd_dir!=cur_dir at period_end: go to RAMP_DOWN if cur_duty>0, else go to DEAD.
    - Otherwise, on step: cur_duty moves 1 toward tgt (+1 if below, -1 if above, hold if equal).
    - If cur_duty==0 and tgt==0 at period_end: go to IDLE.
  - RAMP_DOWN: on step, cur_duty -= 1, ignoring tgt and cmd_dir. When cur_duty==0 at period_end, go to DEAD. The reversal is committed even if cmd_dir reverts.
  - DEAD: counts DEAD_PERIODS period_ends. On the last one: cur_dir<=cmd_dir, then go to RUN if tgt>0, else IDLE.
- busy = (state==RAMP_DOWN or state==DEAD), registered.
- Arithmetic: cur_duty is 8-bit and saturates within 0..100. No wrap below 0 or above 100.

Test Plan:
1. Bench params: PRESCALE=2, PWM_STEPS=100, RAMP_PERIODS=1, DEAD_PERIODS=2. Hold u18=1 for 5 clocks with cmd_duty=50 -> ena=in1=in2=busy=0 and cur_duty=0 throughout; all 0 on the clock after release until the first period_end.
2. cmd_duty=25, cmd_dir=0 from IDLE -> in1=1, in2=0 after the first period_end; cur_duty increments 1 per period and holds at 25 after 25 periods; ena is then high exactly 50 of each 200-clock period.
3. At cur_duty=50 forward, set cmd_dir=1 -> busy=1; cur_duty falls to 0 over 50 periods with in1=1 held; then in1=in2=0 for 2 periods; then in2=1, busy=0, and cur_duty ramps back to 50.
4. cmd_duty=200 -> treated as 100; after ramp-up, ena stays 1 every clock with no low pulse at period wrap.
5. Assert u18 for 1 clock mid-ramp (cur_duty=30) and mid-DEAD -> the following clock shows cur_duty=0, ena=in1=in2=busy=0, state IDLE.
6. In RUN at 10 %, set cmd_duty=0 -> cur_duty decreases to 0 and the FSM returns to IDLE with in1=in2=0. During RAMP_DOWN, toggle cmd_dir back -> the reversal still completes through DEAD.
